bp_update_queue: RTL and testbench
==================================

# bp_update_queue

Retire-side update buffer for the branch predictor. It collects resolved-branch records from the retire stage and presents them, one per cycle, on the predictor's `rt_*` update inputs. Retire can therefore complete branches in cycles where the predictor is stalled (`enable` low) without losing PHT, BTB or RAS updates. The queue sits between retire and BP2 and drives BP2's `rt_*` ports directly.

## Interface
Parameters:
- `DEPTH`, 4: number of buffered records; must be a power of two, ≥2.
- `IDX_W`, `$clog2(`OBQ_SIZE)+1`: width of the OBQ branch index.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `bp_enable`  in  1  the predictor's `enable`; a record is consumed in every cycle this is high and a record is presented.
- `in_valid`  in  1  retire presents a resolved branch.
- `in_cond`, `in_direct`, `in_return`, `in_taken`, `in_correct`  in  1 each  branch class, outcome, and prediction-correct flag.
- `in_pc`  in  32  branch PC.
- `in_target`  in  32  calculated target PC.
- `in_index`  in  IDX_W  OBQ index of the branch.
- `in_ready`  out  1  queue can accept a record this cycle.
- `rt_en_branch`  out  1  update record valid.
- `rt_cond_branch`, `rt_direct_branch`, `rt_return_branch`, `rt_branch_taken`, `rt_prediction_correct`  out  1 each  fields of the head record.
- `rt_pc`, `rt_calculated_pc`  out  32  fields of the head record.
- `rt_branch_index`  out  IDX_W  field of the head record.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `drop_cnt`  out  8  saturating count of dropped records.

## Operation
- Storage is a circular buffer with a `head` pointer, a `tail` pointer (each $clog2(DEPTH) bits, wrapping modulo DEPTH), and `count`.
- **Enqueue** occurs when `in_valid && in_ready`. The record is written at `tail`, and `tail` increments.
- **`in_ready`** equals `count != DEPTH`. It depends on current state only, so a dequeue in the same cycle does not free a slot for that cycle.
- **Dequeue** occurs when `rt_en_branch && bp_enable`. `head` increments.
- **Show-ahead output:** `rt_*` fields always reflect the entry at `head`.
  - `rt_en_branch` equals `count != 0`.
  - When `count == 0`, all `rt_*` fields are 0.
- **Simultaneous enqueue and dequeue** (count between 1 and DEPTH-1): `count` is unchanged and both pointers advance.
- **Dropped records:** if `in_valid && !in_ready`, the record is discarded and `drop_cnt` increments, saturating at 255.
- **Ordering:** records leave in strict retire order; entries are never reordered or merged.
- **Reset** (asynchronous, mid-operation included): `head`, `tail`, `count` and `drop_cnt` are cleared to 0 and all pending records are lost. Outputs are `in_ready`=1, `rt_en_branch`=0, all `rt_*`=0, `count`=0, `drop_cnt`=0. Storage contents need not be cleared, but outputs must be 0 while `count == 0`.

## Timing
- Enqueue latency is 1 cycle: a record accepted at edge N is visible on `rt_*` after edge N (in cycle N+1).
- There is no combinational path from `in_*` to `rt_*`, except as described under Configuration.
- `in_ready` is a registered-state function with no dependency on `bp_enable`.
- Throughput is 1 record per cycle in steady state with `bp_enable` held high.
- While `bp_enable` is low the head record is held stable. `rt_*` must not change until it is consumed.

## Configuration
Macro: `BPQ_BYPASS_EN`.

- **Defined:** when `count == 0 && in_valid && bp_enable`, the incoming record drives `rt_*` combinationally in the same cycle.
  - `rt_en_branch` is 1.
  - The record is consumed immediately and not written to storage; pointers and `count` are unchanged.
  - `in_ready` remains 1 in this case.
  - If `bp_enable` is low, the record is enqueued normally.
- **Undefined:** there is no bypass, and every record incurs the 1-cycle queue latency.

## Test plan
- **Reset:** assert `reset`=0 mid-stream with `count`=3 → outputs immediately `rt_en_branch`=0, all `rt_*`=0, `count`=0, `drop_cnt`=0, `in_ready`=1.
- **Single pass, bypass off:** `bp_enable`=1; enqueue `pc`=0x100, `target`=0x200, `taken`=1, `index`=3 at edge N → in cycle N+1 `rt_en_branch`=1, `rt_pc`=0x100, `rt_calculated_pc`=0x200, `rt_branch_index`=3; in cycle N+2 `rt_en_branch`=0.
- **Stall and fill:** `bp_enable`=0; enqueue PCs 0x10, 0x14, 0x18, 0x1C → `count`=4, `in_ready`=0. A fifth record at 0x20 → `drop_cnt`=1. Raise `bp_enable` → `rt_pc` shows 0x10, 0x14, 0x18, 0x1C on consecutive cycles, then `rt_en_branch`=0.
- **Wrap-around:** stream 10 records with `bp_enable` toggling 1,0,1,0… → output order equals input order, no drops, final `count`=0.
- **Simultaneous:** at `count`=2, enqueue 0x40 while dequeuing → `count` stays 2 and 0x40 emerges after the two older records.
- **Bypass (`BPQ_BYPASS_EN` defined):** empty queue, `bp_enable`=1, `in_pc`=0x300 → same-cycle `rt_en_branch`=1, `rt_pc`=0x300; the next cycle `count`=0.

Source files
------------

// File: rtl/bp_update_queue.sv
// Retire-side update buffer feeding the branch predictor's rt_* update ports (show-ahead FIFO).
// Optional same-cycle bypass of an empty queue is enabled by defining BPQ_BYPASS_EN.
`ifndef OBQ_SIZE
`define OBQ_SIZE 16
`endif

module bp_update_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(`OBQ_SIZE) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     bp_enable,
  input  logic                     in_valid,
  input  logic                     in_cond,
  input  logic                     in_direct,
  input  logic                     in_return,
  input  logic                     in_taken,
  input  logic                     in_correct,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_target,
  input  logic [IDX_W-1:0]         in_index,
  output logic                     in_ready,
  output logic                     rt_en_branch,
  output logic                     rt_cond_branch,
  output logic                     rt_direct_branch,
  output logic                     rt_return_branch,
  output logic                     rt_branch_taken,
  output logic                     rt_prediction_correct,
  output logic [31:0]              rt_pc,
  output logic [31:0]              rt_calculated_pc,
  output logic [IDX_W-1:0]         rt_branch_index,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = 5 + 64 + IDX_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       drop_q, drop_d;

  logic [REC_W-1:0] in_rec_s, out_rec_s;
  logic             empty_s, full_s, bypass_s, enq_s, deq_s;

  assign in_rec_s = {in_cond, in_direct, in_return, in_taken, in_correct,
                     in_pc, in_target, in_index};
  assign empty_s  = (count_q == {CNT_W{1'b0}});
  assign full_s   = (count_q == FULL_CNT);

`ifdef BPQ_BYPASS_EN
  assign bypass_s = empty_s && in_valid && bp_enable;
`else
  assign bypass_s = 1'b0;
`endif

  // a bypassed record is consumed on the spot and never touches storage
  assign enq_s = in_valid && !full_s && !bypass_s;
  assign deq_s = !empty_s && bp_enable;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = drop_q;
    if (enq_s) begin
      tail_d = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    if (deq_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (in_valid && full_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      drop_q  <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {REC_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      if (enq_s) mem_q[tail_q] <= in_rec_s;
    end
  end

  // stale storage must never leak out while the queue is empty
  always_comb begin
    out_rec_s = {REC_W{1'b0}};
    if (!empty_s) begin
      out_rec_s = mem_q[head_q];
    end else if (bypass_s) begin
      out_rec_s = in_rec_s;
    end else begin
      out_rec_s = {REC_W{1'b0}};
    end
  end

  assign {rt_cond_branch, rt_direct_branch, rt_return_branch, rt_branch_taken,
          rt_prediction_correct, rt_pc, rt_calculated_pc, rt_branch_index} = out_rec_s;
  assign rt_en_branch = !empty_s || bypass_s;
  assign in_ready     = !full_s;
  assign count        = count_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed, table-driven bench for bp_update_queue (default build, no bypass).
module tb_bp_update_queue;

  typedef struct packed {
    logic        cond;
    logic        direct;
    logic        ret;
    logic        taken;
    logic        correct;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [4:0]  idx;
  } rec_t;

  typedef struct {
    logic        vld;
    logic        en;
    logic [31:0] pc;
    logic        exp_en;
    logic [31:0] exp_pc;
    logic [2:0]  exp_cnt;
    logic        exp_rdy;
    logic [7:0]  exp_drop;
  } vec_t;

  logic        clock, reset, bp_enable, in_valid;
  logic        in_cond, in_direct, in_return, in_taken, in_correct;
  logic [31:0] in_pc, in_target;
  logic [4:0]  in_index;
  logic        in_ready, rt_en_branch;
  logic        rt_cond_branch, rt_direct_branch, rt_return_branch, rt_branch_taken, rt_prediction_correct;
  logic [31:0] rt_pc, rt_calculated_pc;
  logic [4:0]  rt_branch_index;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  int ntests = 0;
  int nfail  = 0;
  vec_t vecs[20];
  rec_t act_s;

  bp_update_queue #(.DEPTH(4), .IDX_W(5)) dut (
    .clock(clock), .reset(reset), .bp_enable(bp_enable), .in_valid(in_valid),
    .in_cond(in_cond), .in_direct(in_direct), .in_return(in_return),
    .in_taken(in_taken), .in_correct(in_correct), .in_pc(in_pc),
    .in_target(in_target), .in_index(in_index), .in_ready(in_ready),
    .rt_en_branch(rt_en_branch), .rt_cond_branch(rt_cond_branch),
    .rt_direct_branch(rt_direct_branch), .rt_return_branch(rt_return_branch),
    .rt_branch_taken(rt_branch_taken), .rt_prediction_correct(rt_prediction_correct),
    .rt_pc(rt_pc), .rt_calculated_pc(rt_calculated_pc),
    .rt_branch_index(rt_branch_index), .count(count), .drop_cnt(drop_cnt)
  );

  assign act_s = {rt_cond_branch, rt_direct_branch, rt_return_branch, rt_branch_taken,
                  rt_prediction_correct, rt_pc, rt_calculated_pc, rt_branch_index};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every field of a test record is derived from its PC; 0x100 gives target 0x200, taken 1, index 3.
  function automatic rec_t rec_of(input logic [31:0] pc);
    rec_t r;
    logic [31:0] sh;
    sh        = (pc >> 2) + 32'd3;
    r.cond    = pc[3];
    r.direct  = pc[4];
    r.ret     = pc[5];
    r.taken   = ~pc[2];
    r.correct = pc[6];
    r.pc      = pc;
    r.tgt     = pc + 32'h100;
    r.idx     = sh[4:0];
    return r;
  endfunction

  function automatic vec_t mk(input logic vld, input logic en, input logic [31:0] pc,
                              input logic exp_en, input logic [31:0] exp_pc,
                              input logic [2:0] exp_cnt, input logic exp_rdy,
                              input logic [7:0] exp_drop);
    vec_t v;
    v.vld = vld; v.en = en; v.pc = pc; v.exp_en = exp_en; v.exp_pc = exp_pc;
    v.exp_cnt = exp_cnt; v.exp_rdy = exp_rdy; v.exp_drop = exp_drop;
    return v;
  endfunction

  task automatic drive(input logic vld, input logic en, input logic [31:0] pc);
    rec_t r;
    r = rec_of(pc);
    in_valid = vld; bp_enable = en;
    in_cond = r.cond; in_direct = r.direct; in_return = r.ret;
    in_taken = r.taken; in_correct = r.correct;
    in_pc = r.pc; in_target = r.tgt; in_index = r.idx;
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    rec_t e;
    e = v.exp_en ? rec_of(v.exp_pc) : '0;
    check({tag, ".en"},    80'(rt_en_branch), 80'(v.exp_en));
    check({tag, ".rec"},   80'(act_s),        80'(e));
    check({tag, ".count"}, 80'(count),        80'(v.exp_cnt));
    check({tag, ".rdy_drop"}, 80'({in_ready, drop_cnt}), 80'({v.exp_rdy, v.exp_drop}));
  endtask

  initial begin
    logic [31:0] sb[$];
    logic [31:0] exp_pc;
    int k, cyc;

    // single pass, stall-and-fill with a drop, then simultaneous enqueue/dequeue at count 2
    vecs[0]  = mk(1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   3'd0, 1'b1, 8'd0);
    vecs[1]  = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h100, 3'd1, 1'b1, 8'd0);
    vecs[2]  = mk(1'b0, 1'b1, 32'h0,   1'b0, 32'h0,   3'd0, 1'b1, 8'd0);
    vecs[3]  = mk(1'b1, 1'b0, 32'h10,  1'b0, 32'h0,   3'd0, 1'b1, 8'd0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h14,  1'b1, 32'h10,  3'd1, 1'b1, 8'd0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h18,  1'b1, 32'h10,  3'd2, 1'b1, 8'd0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h1C,  1'b1, 32'h10,  3'd3, 1'b1, 8'd0);
    vecs[7]  = mk(1'b1, 1'b0, 32'h20,  1'b1, 32'h10,  3'd4, 1'b0, 8'd0);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  3'd4, 1'b0, 8'd1);
    vecs[9]  = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h10,  3'd4, 1'b0, 8'd1);
    vecs[10] = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h14,  3'd3, 1'b1, 8'd1);
    vecs[11] = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h18,  3'd2, 1'b1, 8'd1);
    vecs[12] = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h1C,  3'd1, 1'b1, 8'd1);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   3'd0, 1'b1, 8'd1);
    vecs[14] = mk(1'b1, 1'b0, 32'h30,  1'b0, 32'h0,   3'd0, 1'b1, 8'd1);
    vecs[15] = mk(1'b1, 1'b0, 32'h34,  1'b1, 32'h30,  3'd1, 1'b1, 8'd1);
    vecs[16] = mk(1'b1, 1'b1, 32'h40,  1'b1, 32'h30,  3'd2, 1'b1, 8'd1);
    vecs[17] = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h34,  3'd2, 1'b1, 8'd1);
    vecs[18] = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h40,  3'd1, 1'b1, 8'd1);
    vecs[19] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   3'd0, 1'b1, 8'd1);

    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check_vec("reset_state", mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b1, 8'd0));
    @(negedge clock);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].vld, vecs[i].en, vecs[i].pc);
      #1;
      check_vec($sformatf("vec%0d", i), vecs[i]);
      @(negedge clock);
    end

    // wrap-around: retire honours in_ready, predictor enable toggles every cycle
    k = 0;
    cyc = 0;
    while (cyc < 100 && !(k == 10 && sb.size() == 0)) begin
      drive((k < 10) && in_ready, (cyc % 2) == 0, 32'h500 + 32'(k * 4));
      #1;
      if (rt_en_branch && bp_enable) begin
        exp_pc = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check($sformatf("wrap_order%0d", cyc), 80'(act_s), 80'(rec_of(exp_pc)));
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_pc);
        k++;
      end
      @(negedge clock);
      cyc++;
    end
    check("wrap_timeout", 80'(cyc < 100), 80'(1));
    drive(1'b0, 1'b0, 32'h0);
    #1;
    check("wrap_final_count", 80'(count), 80'(0));
    check("wrap_no_drops", 80'(drop_cnt), 80'(1));
    @(negedge clock);

    // asynchronous reset with three records pending
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h600 + 32'(i * 4));
      @(negedge clock);
    end
    drive(1'b0, 1'b0, 32'h0);
    #1;
    check("pre_reset_count", 80'(count), 80'(3));
    #2;
    reset = 1'b0;
    #1;
    check_vec("midreset", mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b1, 8'd0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("post_reset_en", 80'(rt_en_branch), 80'(0));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
